// File: rtl/if_id_hazard_ctrl_if.sv
// Signal bundle between the IF/ID pipeline logic and its hazard sequencing controller.
// The master drives the decode lanes and EX hazard flags; the slave returns hold/flush/bubble controls.
interface if_id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [21:0]      dA0;
  logic [21:0]      dA1;
  logic [21:0]      dLS;
  logic [21:0]      dM;
  logic             m_is_mul;
  logic             ex_ld_valid;
  logic [4:0]       ex_ld_rd;
  logic             ex_br_taken;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       busy_state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dA0, dA1, dLS, dM, m_is_mul, ex_ld_valid, ex_ld_rd, ex_br_taken,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_state, stall_cnt
  );

  modport slave (
    input  dA0, dA1, dLS, dM, m_is_mul, ex_ld_valid, ex_ld_rd, ex_br_taken,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_state, stall_cnt
  );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// Stall/flush/bubble sequencer for the four-lane IF/ID register and PC, covering load-use,
// multi-cycle multiply and taken-branch hazards, plus a saturating stall-cycle counter.
module if_id_hazard_ctrl #(
  parameter int MUL_LAT   = 3,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  if_id_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MUL_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam int WAIT_W = $clog2(MUL_LAT + 1);
  localparam int FL_W   = $clog2(FLUSH_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [FL_W-1:0]   FL_LOAD   = FL_W'(FLUSH_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [FL_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c;
  logic pc_hold_g;
  logic lu_haz;
  logic unused_fields;

  function automatic logic src_hit(input logic [21:0] instr, input logic [4:0] rd);
    return (instr[14:10] == rd) || (instr[9:5] == rd);
  endfunction

  assign lu_haz = bus.ex_ld_valid && (bus.ex_ld_rd != 5'd0) &&
                  (src_hit(bus.dA0, bus.ex_ld_rd) || src_hit(bus.dA1, bus.ex_ld_rd) ||
                   src_hit(bus.dLS, bus.ex_ld_rd) || src_hit(bus.dM,  bus.ex_ld_rd));

  // Only the source fields take part in hazard detection.
  assign unused_fields = ^{bus.dA0[21:15], bus.dA0[4:0], bus.dA1[21:15], bus.dA1[4:0],
                           bus.dLS[21:15], bus.dLS[4:0], bus.dM[21:15],  bus.dM[4:0]};

  always_comb begin
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    fcnt_d        = fcnt_q;
    case (state_q)
      ST_RUN, ST_MUL_WAIT: begin
        if (bus.ex_br_taken) begin
          // An older taken branch also kills a multiply still waiting in decode.
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          wait_cnt_d    = '0;
          state_d       = ST_RUN;
          if (FLUSH_CYC > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FL_LOAD;
          end
        end else if (state_q == ST_MUL_WAIT) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
          if (wait_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q - WAIT_W'(1);
          end
        end else if (lu_haz) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (bus.m_is_mul && (MUL_LAT > 1)) begin
          pc_hold_c   = 1'b1;
          ifid_hold_c = 1'b1;
          state_d     = ST_MUL_WAIT;
          wait_cnt_d  = WAIT_LOAD;
        end
      end
      ST_FLUSH: begin
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        if (bus.ex_br_taken) begin
          fcnt_d = FL_LOAD;
        end else if (fcnt_q <= FL_W'(1)) begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FL_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
        fcnt_d     = '0;
      end
    endcase
  end

  assign pc_hold_g = rst_n & pc_hold_c;

  always_comb begin
    stall_d = stall_q;
    if (pc_hold_g && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      fcnt_q     <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fcnt_q     <= fcnt_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.pc_hold     = pc_hold_g;
  assign bus.ifid_hold   = rst_n & ifid_hold_c;
  assign bus.ifid_flush  = rst_n & ifid_flush_c;
  assign bus.idex_bubble = rst_n & idex_bubble_c;
  assign bus.busy_state  = state_q;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl: two configurations driven by the same stimulus and compared
// every cycle against a remaining-cycles reference model.
module tb_if_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] d_a0, d_a1, d_ls, d_m;
  logic        mul, ld_valid, br;
  logic [4:0]  ld_rd;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining flush cycles, remaining multiply wait cycles, stall count.
  int p_mul[2] = '{3, 3};
  int p_fl[2]  = '{1, 3};
  int p_max[2] = '{65535, 15};
  int flush_rem[2];
  int mul_rem[2];
  int cnt[2];
  string nm[2] = '{"a", "b"};

  if_id_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  if_id_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

  assign bus_a.dA0 = d_a0;  assign bus_b.dA0 = d_a0;
  assign bus_a.dA1 = d_a1;  assign bus_b.dA1 = d_a1;
  assign bus_a.dLS = d_ls;  assign bus_b.dLS = d_ls;
  assign bus_a.dM  = d_m;   assign bus_b.dM  = d_m;
  assign bus_a.m_is_mul    = mul;      assign bus_b.m_is_mul    = mul;
  assign bus_a.ex_ld_valid = ld_valid; assign bus_b.ex_ld_valid = ld_valid;
  assign bus_a.ex_ld_rd    = ld_rd;    assign bus_b.ex_ld_rd    = ld_rd;
  assign bus_a.ex_br_taken = br;       assign bus_b.ex_br_taken = br;

  if_id_hazard_ctrl #(.MUL_LAT(3), .FLUSH_CYC(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  if_id_hazard_ctrl #(.MUL_LAT(3), .FLUSH_CYC(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] mk(input int rd, input int rs1, input int rs2);
    logic [21:0] v;
    v = 22'h00000C;
    v[19:15] = 5'(rd);
    v[14:10] = 5'(rs1);
    v[9:5]   = 5'(rs2);
    return v;
  endfunction

  function automatic bit lu_ref();
    logic [21:0] lanes[4];
    bit hit = 0;
    lanes = '{d_a0, d_a1, d_ls, d_m};
    if (!ld_valid || ld_rd == 0) return 0;
    foreach (lanes[i]) if (lanes[i][14:10] == ld_rd || lanes[i][9:5] == ld_rd) hit = 1;
    return hit;
  endfunction

  task automatic idle_inputs();
    d_a0 = 22'h00000C; d_a1 = 22'h00000C; d_ls = 22'h00000C; d_m = 22'h00000C;
    mul = 0; ld_valid = 0; ld_rd = 0; br = 0;
  endtask

  // One clock: check Mealy outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int nfr[2], nmr[2], nc[2];
    bit lu;
    @(negedge clk);
    lu = lu_ref();
    for (int k = 0; k < 2; k++) begin
      bit ph, ih, fl, bb;
      int bs;
      logic [31:0] g_ph, g_ih, g_fl, g_bb, g_bs, g_cnt;
      ph = 0; ih = 0; fl = 0; bb = 0;
      bs = (flush_rem[k] > 0) ? 2 : ((mul_rem[k] > 0) ? 1 : 0);
      nfr[k] = flush_rem[k]; nmr[k] = mul_rem[k]; nc[k] = cnt[k];
      if (!rst_n) begin
        nfr[k] = 0; nmr[k] = 0; nc[k] = 0;
      end else begin
        if (br || flush_rem[k] > 0) begin
          fl = 1; bb = 1;
          nfr[k] = br ? p_fl[k] - 1 : flush_rem[k] - 1;
          nmr[k] = 0;
        end else if (mul_rem[k] > 0) begin
          ph = 1; ih = 1; bb = 1;
          nmr[k] = mul_rem[k] - 1;
        end else if (lu) begin
          ph = 1; ih = 1; bb = 1;
        end else if (mul && p_mul[k] > 1) begin
          ph = 1; ih = 1;
          nmr[k] = p_mul[k] - 1;
        end
        if (ph) nc[k] = (cnt[k] + 1 > p_max[k]) ? p_max[k] : cnt[k] + 1;
      end
      if (k == 0) begin
        g_ph = 32'(bus_a.pc_hold); g_ih = 32'(bus_a.ifid_hold); g_fl = 32'(bus_a.ifid_flush);
        g_bb = 32'(bus_a.idex_bubble); g_bs = 32'(bus_a.busy_state); g_cnt = 32'(bus_a.stall_cnt);
      end else begin
        g_ph = 32'(bus_b.pc_hold); g_ih = 32'(bus_b.ifid_hold); g_fl = 32'(bus_b.ifid_flush);
        g_bb = 32'(bus_b.idex_bubble); g_bs = 32'(bus_b.busy_state); g_cnt = 32'(bus_b.stall_cnt);
      end
      check({nm[k], ".pc_hold"},     g_ph,  32'(ph));
      check({nm[k], ".ifid_hold"},   g_ih,  32'(ih));
      check({nm[k], ".ifid_flush"},  g_fl,  32'(fl));
      check({nm[k], ".idex_bubble"}, g_bb,  32'(bb));
      check({nm[k], ".busy_state"},  g_bs,  32'(bs));
      check({nm[k], ".stall_cnt"},   g_cnt, 32'(cnt[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      flush_rem[k] = nfr[k]; mul_rem[k] = nmr[k]; cnt[k] = nc[k];
    end
    #1;
  endtask

  task automatic run_idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      flush_rem[k] = 0; mul_rem[k] = 0; cnt[k] = 0;
    end
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst_n = 1;
    run_idle(10);
    check("a.stall_after_idle", 32'(bus_a.stall_cnt), 32'd0);

    // Load-use: one-cycle stall, then the same pattern against r0.
    ld_valid = 1; ld_rd = 5; d_ls = mk(0, 5, 0);
    cycle();
    run_idle(2);
    check("a.stall_after_lu", 32'(bus_a.stall_cnt), 32'd1);
    ld_valid = 1; ld_rd = 0; d_ls = mk(0, 0, 0);
    cycle();
    run_idle(1);
    check("a.stall_after_r0", 32'(bus_a.stall_cnt), 32'd1);

    // Multiply: three cycles of decode occupancy.
    mul = 1;
    cycle();
    run_idle(4);
    check("a.stall_after_mul", 32'(bus_a.stall_cnt), 32'd4);

    // Branch on the second MUL_WAIT cycle kills the multiply.
    mul = 1; cycle();
    mul = 0; cycle();
    br = 1;  cycle();
    run_idle(4);
    check("a.stall_after_mul_br", 32'(bus_a.stall_cnt), 32'd6);

    // Branch coincident with load-use and multiply, then an extended flush.
    br = 1; mul = 1; ld_valid = 1; ld_rd = 5; d_ls = mk(0, 5, 0);
    cycle();
    run_idle(4);
    check("a.stall_after_br_prio", 32'(bus_a.stall_cnt), 32'd6);
    br = 1; cycle();
    br = 0; cycle();
    br = 1; cycle();
    run_idle(5);

    // Saturation of the narrow counter, then reset in the middle of MUL_WAIT.
    idle_inputs(); mul = 1;
    for (int i = 0; i < 40; i++) cycle();
    check("b.stall_saturated", 32'(bus_b.stall_cnt), 32'd15);
    run_idle(4);
    mul = 1; cycle();
    mul = 0; cycle();
    rst_n = 0; cycle();
    check("b.state_after_rst", 32'(bus_b.busy_state), 32'd0);
    check("b.stall_after_rst", 32'(bus_b.stall_cnt), 32'd0);
    rst_n = 1;
    run_idle(3);

    // Randomized traffic with a small register set so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      d_a0 = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      d_a1 = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      d_ls = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      d_m  = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      d_a0[21:20] = 2'($urandom_range(0, 3));
      mul      = ($urandom_range(0, 3) == 0);
      ld_valid = ($urandom_range(0, 9) < 3);
      ld_rd    = 5'($urandom_range(0, 7));
      br       = ($urandom_range(0, 9) == 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1;
    run_idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
